led_matrix_scan_driver: RTL and testbench
=========================================

Name: led_matrix_scan_driver

Overview:
- Parametrised row-scanning driver for an LED matrix fed by two daisy-chained 74HC595-style shift-register chains: a column-data chain and a row-select chain.
- Double-buffered frame store: game logic writes the back buffer while the front buffer is scanned. A swap request takes effect at the next frame boundary.
- Generates SRCLK, RCLK, two serial data lines and a blanking output-enable, replacing free-running hand-toggled shift timing with a deterministic FSM.

Parameters:
- ROWS, 16, matrix rows; row-select chain length.
- COLS, 16, matrix columns; column-data chain length.
- TICK_DIV, 25, system clocks per tick (≥2). One shift-clock phase = 1 tick.
- DWELL_TICKS, 1000, ticks each row stays lit (≥1).
- ROW_ACTIVE_LOW, 0, 1 inverts every row-select bit on SER_ROW.
- COL_ACTIVE_LOW, 0, 1 inverts every column bit on SER_COL.

Ports:
- CLK1_50  in  1  system clock, 50 MHz
- CLR  in  1  synchronous reset, active-high
- enable  in  1  scan enable; sampled only at row start
- wr_en  in  1  write strobe for the back buffer
- wr_row  in  clog2(ROWS)  row address of the write
- wr_data  in  COLS  row pixels; bit c = column c, 1 = lit
- swap_req  in  1  one-cycle pulse; request buffer swap
- swap_pending  out  1  swap requested, not yet applied
- SRCLK  out  1  shift clock to both chains
- RCLK  out  1  storage latch clock to both chains
- SER_COL  out  1  serial column data
- SER_ROW  out  1  serial row-select data
- OE_N  out  1  chain output enable, active-low (1 = blank)
- row_idx  out  clog2(ROWS)  row currently latched or lit
- frame_done  out  1  one-cycle pulse after the last row's dwell

Behaviour:
- Reset (CLR=1 at a clock edge):
  - Outputs: SRCLK=0, RCLK=0, SER_COL=0, SER_ROW=0, OE_N=1, row_idx=0, frame_done=0, swap_pending=0.
  - Both buffers cleared to 0; front = buffer 0; tick divider cleared; FSM to IDLE.
  - Reset mid-shift or mid-dwell aborts immediately; no partial latch is issued afterwards.
- Tick: one-cycle strobe every TICK_DIV clocks, free-running from reset. All FSM transitions occur only on tick cycles.
- Shift length L = max(ROWS, COLS). The shorter chain is padded with leading zeros, shifted first, and polarity inversion is not applied to pad bits.
- Column word = front[row_idx]. Row word = one-hot, bit row_idx set. Both words are shifted MSB first, bit index L-1 down to 0.
- FSM states:
  - IDLE: OE_N=1. On tick with enable=1 → BLANK; otherwise stay.
  - BLANK: OE_N=1 for 1 tick → SHIFT_LO with bit counter = L-1.
  - SHIFT_LO: SRCLK=0; present SER_COL/SER_ROW for the current bit → SHIFT_HI after 1 tick.
  - SHIFT_HI: SRCLK=1, data held stable → decrement counter and go to SHIFT_LO; after bit 0 → LATCH.
  - LATCH: SRCLK=0, RCLK=1 for 1 tick → DWELL.
  - DWELL: RCLK=0, OE_N=0 for DWELL_TICKS ticks, then:
    - row_idx < ROWS-1: row_idx+1, then BLANK (or IDLE if enable=0).
    - row_idx = ROWS-1: pulse frame_done, apply a pending swap, row_idx=0, then BLANK (or IDLE if enable=0).
- Row period = (2 + 2L + DWELL_TICKS) ticks. With defaults: 1034 ticks = 25850 clocks per row; 16 rows ≈ 8.27 ms per frame.
- Writes: wr_en=1 writes wr_data into back[wr_row] that cycle. wr_row ≥ ROWS is ignored. Writes never touch the front buffer.
- Swap:
  - swap_req sets swap_pending. A further swap_req while pending has no effect.
  - At the frame boundary, front/back exchange and swap_pending clears in the same cycle as frame_done.
  - A write in the swap cycle lands in the pre-swap back buffer, which becomes the new front.
- The front buffer is sampled at the start of each row's SHIFT, so rows are never torn mid-shift.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then enable=1 with ROWS=COLS=4, TICK_DIV=2, DWELL_TICKS=3 → first SRCLK rising edge 4 clocks after the first tick; 4 SRCLK pulses, then one RCLK pulse 2 clocks wide; OE_N=0 for exactly 6 clocks; row period 26 clocks.
- Write back[1]=4'b1010, swap_req, run 2 frames → frame 1 all SER_COL=0; after frame_done, row-1 shift shows SER_COL sequence 1,0,1,0 and SER_ROW 0,0,1,0.
- ROW_ACTIVE_LOW=1, ROWS=4, COLS=6 → SER_ROW per row = 2 pad zeros, then inverted one-hot (row 2: 0,0,1,0,1,1); SER_COL has no pad.
- swap_req twice within one frame, plus a write to row 0 on the frame_done cycle → exactly one swap; new front row 0 holds the written value; swap_pending=0 afterwards.
- Assert CLR during row 2 SHIFT_HI → next clock SRCLK=0, OE_N=1, row_idx=0, buffers zero; no RCLK pulse until the next full shift.
- Drop enable during row 1 DWELL → dwell completes, row_idx=2, FSM in IDLE with OE_N=1; re-raise enable → scan resumes at row 2.

Source files
------------

// File: rtl/led_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scan_driver
//  Purpose  : Row-scanning driver for an LED matrix fed by two daisy-chained
//             74HC595-style chains (column data + row select). Double-buffered
//             frame store; swaps take effect at the frame boundary.
//  Revision : 1.0  initial release
// ============================================================================
module led_matrix_scan_driver #(
  parameter int ROWS           = 16,
  parameter int COLS           = 16,
  parameter int TICK_DIV       = 25,
  parameter int DWELL_TICKS    = 1000,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             CLK1_50,
  input  logic             CLR,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             swap_req,
  output logic             swap_pending,
  output logic             SRCLK,
  output logic             RCLK,
  output logic             SER_COL,
  output logic             SER_ROW,
  output logic             OE_N,
  output logic [ROW_W-1:0] row_idx,
  output logic             frame_done
);

  // Both chains are clocked together, so the shift length is the longer one.
  localparam int L     = (ROWS > COLS) ? ROWS : COLS;
  localparam int BIT_W = (L > 1) ? $clog2(L) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BLANK    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_LATCH    = 3'd4,
    S_DWELL    = 3'd5
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic [DW_W-1:0]  dwell_q;
  logic [ROW_W-1:0] row_q;
  logic [COLS-1:0]  col_word_q;
  logic             front_sel_q;
  logic             swap_pending_q;
  logic             srclk_q;
  logic             rclk_q;
  logic             ser_col_q;
  logic             ser_row_q;
  logic             oe_n_q;
  logic             frame_done_q;

  // front_sel_q = 0: buffer 0 is scanned, buffer 1 takes writes.
  logic [COLS-1:0]  buf0_q [ROWS];
  logic [COLS-1:0]  buf1_q [ROWS];

  logic             w_tick;
  logic [COLS-1:0]  w_front_row;
  logic [ROWS-1:0]  w_onehot;
  logic [L-1:0]     w_col_pad_new;
  logic [L-1:0]     w_col_pad;
  logic [L-1:0]     w_row_pad;
  logic [BIT_W-1:0] w_bit_nxt;
  logic             w_wr_ok;

  assign w_tick      = (div_q == DIV_W'(TICK_DIV - 1));
  assign w_front_row = front_sel_q ? buf1_q[row_q] : buf0_q[row_q];
  assign w_onehot    = ROWS'(1) << row_q;
  // Zero-extension after inversion keeps the leading pad bits at 0.
  assign w_col_pad_new = L'(w_front_row ^ {COLS{COL_ACTIVE_LOW}});
  assign w_col_pad     = L'(col_word_q  ^ {COLS{COL_ACTIVE_LOW}});
  assign w_row_pad     = L'(w_onehot    ^ {ROWS{ROW_ACTIVE_LOW}});
  assign w_bit_nxt     = bit_q - BIT_W'(1);
  assign w_wr_ok       = wr_en && (int'(wr_row) < ROWS);

  // Free-running tick divider.
  always_ff @(posedge CLK1_50) begin
    if (CLR) begin
      div_q <= '0;
    end else if (w_tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Back-buffer writes; the back buffer is whichever one is not being scanned.
  always_ff @(posedge CLK1_50) begin
    if (CLR) begin
      for (int r = 0; r < ROWS; r++) begin
        buf0_q[r] <= '0;
        buf1_q[r] <= '0;
      end
    end else if (w_wr_ok) begin
      if (front_sel_q) begin
        buf0_q[wr_row] <= wr_data;
      end else begin
        buf1_q[wr_row] <= wr_data;
      end
    end
  end

  // Scan FSM with registered chain outputs; advances only on tick cycles.
  always_ff @(posedge CLK1_50) begin
    if (CLR) begin
      state_q        <= S_IDLE;
      bit_q          <= '0;
      dwell_q        <= '0;
      row_q          <= '0;
      col_word_q     <= '0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      srclk_q        <= 1'b0;
      rclk_q         <= 1'b0;
      ser_col_q      <= 1'b0;
      ser_row_q      <= 1'b0;
      oe_n_q         <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (swap_req) begin
        swap_pending_q <= 1'b1;
      end
      if (w_tick) begin
        unique case (state_q)
          S_IDLE: begin
            oe_n_q <= 1'b1;
            if (enable) begin
              state_q <= S_BLANK;
            end
          end
          S_BLANK: begin
            // Snapshot the row here so a swap or write cannot tear it mid-shift.
            col_word_q <= w_front_row;
            bit_q      <= BIT_W'(L - 1);
            srclk_q    <= 1'b0;
            ser_col_q  <= w_col_pad_new[L-1];
            ser_row_q  <= w_row_pad[L-1];
            state_q    <= S_SHIFT_LO;
          end
          S_SHIFT_LO: begin
            srclk_q <= 1'b1;
            state_q <= S_SHIFT_HI;
          end
          S_SHIFT_HI: begin
            srclk_q <= 1'b0;
            if (bit_q == '0) begin
              rclk_q  <= 1'b1;
              state_q <= S_LATCH;
            end else begin
              bit_q     <= w_bit_nxt;
              ser_col_q <= w_col_pad[w_bit_nxt];
              ser_row_q <= w_row_pad[w_bit_nxt];
              state_q   <= S_SHIFT_LO;
            end
          end
          S_LATCH: begin
            rclk_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            dwell_q <= '0;
            state_q <= S_DWELL;
          end
          S_DWELL: begin
            if (dwell_q == DW_W'(DWELL_TICKS - 1)) begin
              oe_n_q  <= 1'b1;
              state_q <= enable ? S_BLANK : S_IDLE;
              if (row_q == ROW_W'(ROWS - 1)) begin
                row_q        <= '0;
                frame_done_q <= 1'b1;
                if (swap_pending_q) begin
                  front_sel_q    <= ~front_sel_q;
                  swap_pending_q <= 1'b0;
                end
              end else begin
                row_q <= row_q + ROW_W'(1);
              end
            end else begin
              dwell_q <= dwell_q + DW_W'(1);
            end
          end
          default: begin
            oe_n_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign swap_pending = swap_pending_q;
  assign SRCLK        = srclk_q;
  assign RCLK         = rclk_q;
  assign SER_COL      = ser_col_q;
  assign SER_ROW      = ser_row_q;
  assign OE_N         = oe_n_q;
  assign row_idx      = row_q;
  assign frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_matrix_scan_driver
//  Purpose  : Self-checking bench for led_matrix_scan_driver: a 4x4 unit for
//             timing, swap, reset and enable behaviour, and a 4x6 unit with
//             active-low row select for padding and polarity.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_matrix_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic CLR;

  // Unit A: ROWS=4, COLS=4, TICK_DIV=2, DWELL_TICKS=3
  logic       a_en, a_wr_en, a_swap;
  logic [1:0] a_wr_row;
  logic [3:0] a_wr_data;
  logic       a_pend, a_srclk, a_rclk, a_scol, a_srow, a_oen, a_fd;
  logic [1:0] a_row;

  // Unit B: ROWS=4, COLS=6, TICK_DIV=2, DWELL_TICKS=1, ROW_ACTIVE_LOW=1
  logic       b_en, b_wr_en, b_swap;
  logic [1:0] b_wr_row;
  logic [5:0] b_wr_data;
  logic       b_pend, b_srclk, b_rclk, b_scol, b_srow, b_oen, b_fd;
  logic [1:0] b_row;

  led_matrix_scan_driver #(
    .ROWS(4), .COLS(4), .TICK_DIV(2), .DWELL_TICKS(3),
    .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)
  ) dut_a (
    .CLK1_50(clk), .CLR(CLR), .enable(a_en), .wr_en(a_wr_en),
    .wr_row(a_wr_row), .wr_data(a_wr_data), .swap_req(a_swap),
    .swap_pending(a_pend), .SRCLK(a_srclk), .RCLK(a_rclk),
    .SER_COL(a_scol), .SER_ROW(a_srow), .OE_N(a_oen),
    .row_idx(a_row), .frame_done(a_fd)
  );

  led_matrix_scan_driver #(
    .ROWS(4), .COLS(6), .TICK_DIV(2), .DWELL_TICKS(1),
    .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)
  ) dut_b (
    .CLK1_50(clk), .CLR(CLR), .enable(b_en), .wr_en(b_wr_en),
    .wr_row(b_wr_row), .wr_data(b_wr_data), .swap_req(b_swap),
    .swap_pending(b_pend), .SRCLK(b_srclk), .RCLK(b_rclk),
    .SER_COL(b_scol), .SER_ROW(b_srow), .OE_N(b_oen),
    .row_idx(b_row), .frame_done(b_fd)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fd(input bit unit_b, input string name);
    int   n;
    logic fd;
    n  = 0;
    fd = 1'b0;
    while (!fd && n < 1000) begin
      @(negedge clk);
      n++;
      fd = unit_b ? b_fd : a_fd;
    end
    checks++;
    if (!fd) begin
      errors++;
      $display("FAIL %s: frame_done not seen in %0d clocks (got 0, expected 1)", name, n);
    end
  endtask

  // Chain models: shift on SRCLK rise, capture the word at RCLK rise per row.
  logic [15:0] a_sh_col = '0, a_sh_row = '0;
  int          a_nb = 0;
  logic        a_psr = 1'b0, a_prc = 1'b0;
  logic [15:0] a_cap_col [4] = '{default: '0};
  logic [15:0] a_cap_row [4] = '{default: '0};
  int          a_cap_n   [4] = '{default: 0};

  always @(negedge clk) begin
    a_psr <= a_srclk;
    a_prc <= a_rclk;
    if (CLR) begin
      a_sh_col <= '0; a_sh_row <= '0; a_nb <= 0;
    end else if (a_srclk && !a_psr) begin
      a_sh_col <= {a_sh_col[14:0], a_scol};
      a_sh_row <= {a_sh_row[14:0], a_srow};
      a_nb     <= a_nb + 1;
    end else if (a_rclk && !a_prc) begin
      a_cap_col[a_row] <= a_sh_col;
      a_cap_row[a_row] <= a_sh_row;
      a_cap_n[a_row]   <= a_nb;
      a_sh_col <= '0; a_sh_row <= '0; a_nb <= 0;
    end
  end

  logic [15:0] b_sh_col = '0, b_sh_row = '0;
  int          b_nb = 0;
  logic        b_psr = 1'b0, b_prc = 1'b0;
  logic [15:0] b_cap_col [4] = '{default: '0};
  logic [15:0] b_cap_row [4] = '{default: '0};
  int          b_cap_n   [4] = '{default: 0};

  always @(negedge clk) begin
    b_psr <= b_srclk;
    b_prc <= b_rclk;
    if (CLR) begin
      b_sh_col <= '0; b_sh_row <= '0; b_nb <= 0;
    end else if (b_srclk && !b_psr) begin
      b_sh_col <= {b_sh_col[14:0], b_scol};
      b_sh_row <= {b_sh_row[14:0], b_srow};
      b_nb     <= b_nb + 1;
    end else if (b_rclk && !b_prc) begin
      b_cap_col[b_row] <= b_sh_col;
      b_cap_row[b_row] <= b_sh_row;
      b_cap_n[b_row]   <= b_nb;
      b_sh_col <= '0; b_sh_row <= '0; b_nb <= 0;
    end
  end

  typedef struct {
    logic [1:0]  row;
    logic [5:0]  data;
    logic [15:0] exp_col;
    logic [15:0] exp_row;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, first_sr, sr_rises, rclk_w, oe_w, rc1, rc2, act;
    logic psr, prc;

    // 4x6 unit: two leading pad zeros, then inverted one-hot row select.
    tbl[0] = '{2'd0, 6'b110101, 16'h0035, 16'b001110};
    tbl[1] = '{2'd1, 6'b000001, 16'h0001, 16'b001101};
    tbl[2] = '{2'd2, 6'b101010, 16'h002A, 16'b001011};
    tbl[3] = '{2'd3, 6'b011110, 16'h001E, 16'b000111};

    CLR = 1'b1;
    a_en = 1'b0; a_wr_en = 1'b0; a_swap = 1'b0; a_wr_row = '0; a_wr_data = '0;
    b_en = 1'b0; b_wr_en = 1'b0; b_swap = 1'b0; b_wr_row = '0; b_wr_data = '0;
    repeat (3) @(negedge clk);

    chk("rst_srclk",   32'(a_srclk), 0);
    chk("rst_rclk",    32'(a_rclk),  0);
    chk("rst_ser_col", 32'(a_scol),  0);
    chk("rst_ser_row", 32'(a_srow),  0);
    chk("rst_oe_n",    32'(a_oen),   1);
    chk("rst_row_idx", 32'(a_row),   0);
    chk("rst_fd",      32'(a_fd),    0);
    chk("rst_pending", 32'(a_pend),  0);
    chk("rst_b_oe_n",  32'(b_oen),   1);

    // Basic timing of the first row and row period.
    CLR = 1'b0; a_en = 1'b1; b_en = 1'b1;
    first_sr = -1; sr_rises = 0; rclk_w = 0; oe_w = 0; rc1 = -1; rc2 = -1;
    psr = 1'b0; prc = 1'b0;
    for (n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (a_srclk && !psr) begin
        if (first_sr < 0) first_sr = n;
        if (rc1 < 0) sr_rises++;
      end
      if (a_rclk && !prc) begin
        if (rc1 < 0) rc1 = n;
        else if (rc2 < 0) rc2 = n;
      end
      if (a_rclk && rc2 < 0) rclk_w++;
      if (!a_oen && rc2 < 0) oe_w++;
      psr = a_srclk;
      prc = a_rclk;
    end
    chk("first_srclk_rise_clk", first_sr, 6);
    chk("srclk_pulses_row0",    sr_rises, 4);
    chk("rclk_width",           rclk_w,   2);
    chk("oe_low_width",         oe_w,     6);
    chk("row_period",           rc2 - rc1, 26);

    // Write back[1], request swap; first frame still shows blank columns.
    a_wr_en = 1'b1; a_wr_row = 2'd1; a_wr_data = 4'b1010; a_swap = 1'b1;
    @(negedge clk);
    a_wr_en = 1'b0; a_swap = 1'b0;
    chk("swap_pending_set", 32'(a_pend), 1);
    wait_fd(1'b0, "fd_frame1");
    chk("swap_pending_clear_at_fd", 32'(a_pend), 0);
    for (int r = 0; r < 4; r++) begin
      chk("frame1_col",   a_cap_col[r], 32'h0);
      chk("frame1_row",   a_cap_row[r], 32'(1) << r);
      chk("frame1_nbits", a_cap_n[r],   4);
    end
    wait_fd(1'b0, "fd_frame2");
    chk("frame2_row1_col", a_cap_col[1], 32'h000A);
    chk("frame2_row1_sel", a_cap_row[1], 32'h0002);
    chk("frame2_row0_col", a_cap_col[0], 32'h0);

    // Two swap requests in one frame plus a write in the swap cycle.
    a_swap = 1'b1;
    for (int k = 1; k <= 103; k++) begin
      @(negedge clk);
      if (k == 1)  begin a_swap = 1'b0; chk("pend_after_req1", 32'(a_pend), 1); end
      if (k == 20) a_swap = 1'b1;
      if (k == 21) begin a_swap = 1'b0; chk("pend_after_req2", 32'(a_pend), 1); end
      if (k == 103) begin a_wr_en = 1'b1; a_wr_row = 2'd0; a_wr_data = 4'b0110; end
    end
    @(negedge clk);
    a_wr_en = 1'b0;
    chk("fd_on_predicted_cycle", 32'(a_fd),   1);
    chk("pend_clear_on_swap",    32'(a_pend), 0);
    wait_fd(1'b0, "fd_after_swap_a");
    chk("newfront_row0", a_cap_col[0], 32'h0006);
    chk("newfront_row1", a_cap_col[1], 32'h0000);
    wait_fd(1'b0, "fd_after_swap_b");
    chk("single_swap_row0", a_cap_col[0], 32'h0006);
    chk("single_swap_row1", a_cap_col[1], 32'h0000);
    chk("pend_stays_clear", 32'(a_pend), 0);

    // Drop enable during row 1 dwell, then resume.
    n = 0;
    while (!(a_row == 2'd1 && !a_oen) && n < 300) begin @(negedge clk); n++; end
    chk("reach_row1_dwell", 32'(a_row == 2'd1 && !a_oen), 1);
    a_en = 1'b0;
    n = 0;
    while (!a_oen && n < 50) begin @(negedge clk); n++; end
    chk("dwell_end_row_idx", 32'(a_row), 2);
    chk("dwell_end_blank",   32'(a_oen), 1);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_srclk || a_rclk || !a_oen) act++;
    end
    chk("idle_no_activity", act, 0);
    a_en = 1'b1;
    n = 0;
    while (!a_rclk && n < 100) begin @(negedge clk); n++; end
    chk("resume_rclk_seen",  32'(a_rclk), 1);
    chk("resume_latch_row",  32'(a_row),  2);

    // Reset during row 2 SHIFT_HI.
    n = 0;
    while (!(a_row == 2'd2 && a_srclk) && n < 300) begin @(negedge clk); n++; end
    chk("reach_row2_shift_hi", 32'(a_row == 2'd2 && a_srclk), 1);
    CLR = 1'b1;
    @(negedge clk);
    chk("clr_srclk", 32'(a_srclk), 0);
    chk("clr_oe_n",  32'(a_oen),   1);
    chk("clr_row",   32'(a_row),   0);
    chk("clr_rclk",  32'(a_rclk),  0);
    chk("clr_fd",    32'(a_fd),    0);
    @(negedge clk);
    CLR = 1'b0;
    sr_rises = 0; psr = a_srclk; n = 0;
    while (!a_rclk && n < 100) begin
      @(negedge clk);
      n++;
      if (a_srclk && !psr) sr_rises++;
      psr = a_srclk;
    end
    chk("post_clr_full_shift", sr_rises, 4);
    chk("post_clr_latch_row",  32'(a_row), 0);
    wait_fd(1'b0, "fd_post_clr");
    for (int r = 0; r < 4; r++) chk("post_clr_front_zero", a_cap_col[r], 32'h0);
    a_swap = 1'b1;
    @(negedge clk);
    a_swap = 1'b0;
    wait_fd(1'b0, "fd_post_clr_swap");
    wait_fd(1'b0, "fd_post_clr_back");
    for (int r = 0; r < 4; r++) chk("post_clr_back_zero", a_cap_col[r], 32'h0);

    // Padding and active-low row select on the 4x6 unit.
    for (int i = 0; i < 4; i++) begin
      b_wr_en = 1'b1; b_wr_row = tbl[i].row; b_wr_data = tbl[i].data;
      @(negedge clk);
    end
    b_wr_en = 1'b0; b_swap = 1'b1;
    @(negedge clk);
    b_swap = 1'b0;
    wait_fd(1'b1, "b_fd_swap");
    wait_fd(1'b1, "b_fd_frame");
    for (int i = 0; i < 4; i++) begin
      chk("b_col_word",  b_cap_col[tbl[i].row], 32'(tbl[i].exp_col));
      chk("b_row_word",  b_cap_row[tbl[i].row], 32'(tbl[i].exp_row));
      chk("b_nbits",     b_cap_n[tbl[i].row],   6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
